// File: rtl/enum_code_sequencer.sv
// rtl/enum_code_sequencer.sv - steps enum-coded words onto a valid/ready output with programmable hold
package pkg1;
  typedef enum logic [4:0] {
    FIRST  = 5'h07,
    SECOND = 5'h1C
  } enum1;
endpackage

package pkg2;
  typedef enum logic [5:0] {
    THIRD  = 6'h07,
    FOURTH = 6'h38
  } enum1;
endpackage

package pkg3;
  typedef enum logic [6:0] {
    FIFTH = 7'h1C,
    SIXTH = 7'h63
  } enum2;
endpackage

module enum_code_sequencer #(
  parameter int NUM_STEPS   = 4,
  parameter int HOLD_CYCLES = 2,
  parameter int STEP_W      = (NUM_STEPS > 2) ? $clog2(NUM_STEPS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [4:0]        var1,
  output logic [5:0]        var2,
  output logic [6:0]        var3,
  output logic [7:0]        var4,
  output logic [STEP_W-1:0] step,
  output logic              busy,
  output logic              done
);
  import pkg3::*;

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [STEP_W-1:0] LAST_STEP   = STEP_W'(NUM_STEPS - 1);
  localparam logic [CNT_W-1:0]  HOLD_RELOAD = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [7:0] {
    SEVENTH = 8'h5A,
    EIGHTH  = 8'hD3
  } enum3;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    EMIT,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [STEP_W-1:0] step_nx;
  pkg1::enum1  var1_q, var1_d;
  pkg2::enum1  var2_q, var2_d;
  enum2        var3_q, var3_d;
  enum3        var4_q, var4_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        load_codes;
  logic        load_odd;

  assign step_nx = step_q + STEP_W'(1);

  // Next-state, next-output and code-table selection; every output is taken from a register
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    step_d     = step_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    load_codes = 1'b0;
    load_odd   = 1'b0;
    var1_d     = var1_q;
    var2_d     = var2_q;
    var3_d     = var3_q;
    var4_d     = var4_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = HOLD;
          step_d     = '0;
          cnt_d      = HOLD_RELOAD;
          busy_d     = 1'b1;
          load_codes = 1'b1;
        end
      end
      HOLD: begin
        if (abort) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          step_d  = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = EMIT;
          valid_d = 1'b1;
        end
      end
      EMIT: begin
        // Abort takes priority, so a coincident handshake is dropped
        if (abort) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          step_d  = '0;
        end else if (out_ready) begin
          valid_d = 1'b0;
          if (step_q == LAST_STEP) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d    = HOLD;
            step_d     = step_nx;
            cnt_d      = HOLD_RELOAD;
            load_codes = 1'b1;
            load_odd   = step_nx[0];
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    if (load_codes) begin
      var1_d = load_odd ? pkg1::SECOND : pkg1::FIRST;
      var2_d = load_odd ? pkg2::FOURTH : pkg2::THIRD;
      var3_d = load_odd ? SIXTH : FIFTH;
      var4_d = load_odd ? EIGHTH : SEVENTH;
    end
  end

  // State and output registers; reset leaves the even-step codes on the outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      step_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      var1_q  <= pkg1::FIRST;
      var2_q  <= pkg2::THIRD;
      var3_q  <= FIFTH;
      var4_q  <= SEVENTH;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      var1_q  <= var1_d;
      var2_q  <= var2_d;
      var3_q  <= var3_d;
      var4_q  <= var4_d;
    end
  end

  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign step      = step_q;
  assign var1      = var1_q;
  assign var2      = var2_q;
  assign var3      = var3_q;
  assign var4      = var4_q;

endmodule

// File: tb/tb_enum_code_sequencer.sv
// tb/tb_enum_code_sequencer.sv - self-checking bench for enum_code_sequencer
module tb_enum_code_sequencer;
  localparam int NUM_STEPS   = 4;
  localparam int HOLD_CYCLES = 2;
  localparam int STEP_W      = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic              out_ready;
  logic              out_valid;
  logic [4:0]        var1;
  logic [5:0]        var2;
  logic [6:0]        var3;
  logic [7:0]        var4;
  logic [STEP_W-1:0] step;
  logic              busy;
  logic              done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;

  enum_code_sequencer #(
    .NUM_STEPS  (NUM_STEPS),
    .HOLD_CYCLES(HOLD_CYCLES),
    .STEP_W     (STEP_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .var1     (var1),
    .var2     (var2),
    .var3     (var3),
    .var4     (var4),
    .step     (step),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  // code table indexed by step parity
  logic [4:0] t1 [2] = '{5'h07, 5'h1C};
  logic [5:0] t2 [2] = '{6'h07, 6'h38};
  logic [6:0] t3 [2] = '{7'h1C, 7'h63};
  logic [7:0] t4 [2] = '{8'h5A, 8'hD3};

  // model: a run is active, with a step index and cycles spent in that step
  int m_active = 0;
  int m_step   = 0;
  int m_age    = 0;
  int m_done   = 0;
  int m_par    = 0;

  function automatic int exp_valid();
    return (m_active != 0 && m_age >= HOLD_CYCLES) ? 1 : 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      m_active <= 0; m_step <= 0; m_age <= 0; m_done <= 0; m_par <= 0;
    end else if (m_active != 0) begin
      m_done <= 0;
      if (abort) begin
        m_active <= 0; m_step <= 0;
      end else if (exp_valid() != 0 && out_ready) begin
        if (m_step == NUM_STEPS - 1) begin
          m_active <= 0; m_done <= 1;
        end else begin
          m_step <= m_step + 1; m_par <= (m_step + 1) % 2; m_age <= 0;
        end
      end else if (m_age < HOLD_CYCLES) begin
        m_age <= m_age + 1;
      end
    end else begin
      m_done <= 0;
      if (start && m_done == 0) begin
        m_active <= 1; m_step <= 0; m_age <= 0; m_par <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("cmp_out_valid", 32'(out_valid), 32'(exp_valid()));
      chk("cmp_busy", 32'(busy), 32'(m_active));
      chk("cmp_done", 32'(done), 32'(m_done));
      chk("cmp_step", 32'(step), 32'(m_step));
      chk("cmp_var1", 32'(var1), 32'(t1[m_par]));
      chk("cmp_var2", 32'(var2), 32'(t2[m_par]));
      chk("cmp_var3", 32'(var3), 32'(t3[m_par]));
      chk("cmp_var4", 32'(var4), 32'(t4[m_par]));
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic chk_reset(input string nm);
    chk({nm, "_out_valid"}, 32'(out_valid), 0);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_done"}, 32'(done), 0);
    chk({nm, "_step"}, 32'(step), 0);
    chk({nm, "_var1"}, 32'(var1), 32'h07);
    chk({nm, "_var2"}, 32'(var2), 32'h07);
    chk({nm, "_var3"}, 32'(var3), 32'h1C);
    chk({nm, "_var4"}, 32'(var4), 32'h5A);
  endtask

  task automatic wait_for(input int s, input logic v, input string nm);
    int n;
    n = 0;
    while (!(32'(step) == s && out_valid === v && busy === 1'b1) && n < 60) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL %s timeout actual=not_reached required=step%0d_valid%0d", nm, s, v);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_reset("idle");

    // full run, out_ready held high, start asserted for the edge 0
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("edge0_busy", 32'(busy), 1);
    chk("edge0_valid", 32'(out_valid), 0);
    @(negedge clk);
    chk("edge1_valid", 32'(out_valid), 0);
    @(negedge clk);
    chk("edge2_valid", 32'(out_valid), 1);
    chk("edge2_step", 32'(step), 0);
    chk("edge2_var4", 32'(var4), 32'h5A);
    // start while busy must be ignored
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_for(1, 1'b1, "run1_step1");
    chk("step1_var1", 32'(var1), 32'h1C);
    chk("step1_var2", 32'(var2), 32'h38);
    chk("step1_var3", 32'(var3), 32'h63);
    chk("step1_var4", 32'(var4), 32'hD3);
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("run1_done_seen", 32'(done), 1);
    chk("run1_done_busy", 32'(busy), 0);
    chk("run1_done_step", 32'(step), 3);
    chk("run1_done_var1", 32'(var1), 32'h1C);
    // start while in DONE must be ignored
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("after_done_busy", 32'(busy), 0);
    chk("after_done_done", 32'(done), 0);
    chk("after_done_var3", 32'(var3), 32'h63);
    @(negedge clk);
    chk("idle_stays_busy", 32'(busy), 0);

    // backpressure at step 1
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_for(1, 1'b1, "run2_step1");
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_step", 32'(step), 1);
      chk("bp_var1", 32'(var1), 32'h1C);
      chk("bp_var2", 32'(var2), 32'h38);
      chk("bp_var3", 32'(var3), 32'h63);
      chk("bp_var4", 32'(var4), 32'hD3);
    end
    out_ready = 1'b1;
    wait_for(2, 1'b1, "run2_step2");
    chk("step2_var1", 32'(var1), 32'h07);
    chk("step2_var4", 32'(var4), 32'h5A);

    // abort coincident with a handshake at step 2
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_step", 32'(step), 0);
    chk("abort_valid", 32'(out_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_var2", 32'(var2), 32'h07);
    @(negedge clk);
    chk("abort_no_done", 32'(done), 0);

    // restart, then reset in HOLD of step 3
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_step", 32'(step), 0);
    chk("restart_busy", 32'(busy), 1);
    wait_for(3, 1'b0, "run3_hold3");
    chk("hold3_var1", 32'(var1), 32'h1C);
    rst = 1'b1;
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    chk_reset("midrun_rst");
    repeat (3) @(negedge clk);
    chk("done_pulses", 32'(done_cnt), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
